// File: rtl/arbiter_router_top_if.sv
// Request/grant and serial data lanes between the input ports and the arbiter/router stage.
// master: port side driving requests and data; slave: the arbiter.
interface arbiter_router_top_if #(
   parameter int unsigned NPORTS = 16,
   parameter int unsigned IDW    = 4
);
   logic [NPORTS-1:0] request;
   logic [NPORTS-1:0] frame_n;
   logic [NPORTS-1:0] valid_n;
   logic [NPORTS-1:0] din;
   logic [NPORTS-1:0] grant;
   logic              busy;
   logic [IDW-1:0]    grant_id;
   logic              frame_n_o;
   logic              valid_n_o;
   logic              din_o;

   modport master (
      output request, frame_n, valid_n, din,
      input  grant, busy, grant_id, frame_n_o, valid_n_o, din_o
   );

   modport slave (
      input  request, frame_n, valid_n, din,
      output grant, busy, grant_id, frame_n_o, valid_n_o, din_o
   );
endinterface

// File: rtl/arbiter_router_top.sv
// Input-port arbiter with hold-until-release grant and granted-port data select.
// Define RR_ARB_EN for round-robin arbitration; otherwise lowest index wins.
module arbiter_router_top #(
   parameter int unsigned NPORTS = 16,
   parameter int unsigned IDW    = 4
) (
   input logic                  clock,
   input logic                  reset,
   arbiter_router_top_if.slave  bus
);

   typedef enum logic [0:0] {StIdle, StOwned} state_e;

   state_e            state_q, state_d;
   logic [NPORTS-1:0] grant_q, grant_d;
   logic [IDW-1:0]    gid_q, gid_d;
   logic              win_found;
   logic [IDW-1:0]    win_idx;
`ifdef RR_ARB_EN
   logic [IDW-1:0]    ptr_q, ptr_d;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         grant_q <= '0;
         gid_q   <= '0;
`ifdef RR_ARB_EN
         ptr_q   <= IDW'(NPORTS - 1);
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gid_q   <= gid_d;
`ifdef RR_ARB_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   // Winner search; index arithmetic wraps naturally since NPORTS is a power of two.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
`ifdef RR_ARB_EN
      for (int unsigned i = 1; i <= NPORTS; i++) begin
         if (!win_found && bus.request[ptr_q + IDW'(i)]) begin
            win_found = 1'b1;
            win_idx   = ptr_q + IDW'(i);
         end
      end
`else
      for (int unsigned i = 0; i < NPORTS; i++) begin
         if (!win_found && bus.request[i]) begin
            win_found = 1'b1;
            win_idx   = IDW'(i);
         end
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gid_d   = gid_q;
`ifdef RR_ARB_EN
      ptr_d   = ptr_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (win_found) begin
               state_d          = StOwned;
               gid_d            = win_idx;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
            end
         end
         StOwned: begin
            if (!bus.request[gid_q]) begin
               state_d = StIdle;
               grant_d = '0;
               gid_d   = '0;
`ifdef RR_ARB_EN
               ptr_d   = gid_q;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.grant    = grant_q;
      bus.busy     = |grant_q;
      bus.grant_id = gid_q;
      if (state_q == StOwned) begin
         bus.frame_n_o = bus.frame_n[gid_q];
         bus.valid_n_o = bus.valid_n[gid_q];
         bus.din_o     = bus.din[gid_q];
      end else begin
         bus.frame_n_o = 1'b1;
         bus.valid_n_o = 1'b1;
         bus.din_o     = 1'b0;
      end
   end

endmodule

// File: tb/tb_arbiter_router_top.sv
// Randomized self-checking bench for arbiter_router_top against a behavioural owner/pointer model.
// Honours RR_ARB_EN the same way as the design.
module tb_arbiter_router_top;
   localparam int NP = 16;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   tests  = 0;
   int   failed = 0;

   // Model: owner is the granted port or -1 when idle; ptr is the round-robin pointer.
   int   owner = -1;
   int   ptr   = NP - 1;
   logic [NP-1:0] fr, vl, dn;

   arbiter_router_top_if #(.NPORTS(NP), .IDW(4)) bus ();

   arbiter_router_top #(.NPORTS(NP), .IDW(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   function automatic logic [23:0] exp_vec();
      logic [NP-1:0] g;
      logic [3:0]    id;
      g  = '0;
      id = '0;
      if (owner >= 0) begin
         g[owner] = 1'b1;
         id       = 4'(owner);
         return {g, 1'b1, id, fr[owner], vl[owner], dn[owner]};
      end
      return {g, 1'b0, id, 1'b1, 1'b1, 1'b0};
   endfunction

   function automatic logic [23:0] obs_vec();
      return {bus.grant, bus.busy, bus.grant_id, bus.frame_n_o, bus.valid_n_o, bus.din_o};
   endfunction

   task automatic rand_data();
      fr = 16'($urandom);
      vl = 16'($urandom);
      dn = 16'($urandom);
      bus.frame_n = fr;
      bus.valid_n = vl;
      bus.din     = dn;
   endtask

   task automatic model_edge(input logic [NP-1:0] req, input logic rst);
      int c;
      if (rst) begin
         owner = -1;
         ptr   = NP - 1;
      end else if (owner < 0) begin
`ifdef RR_ARB_EN
         for (int k = 1; k <= NP; k++) begin
            c = (ptr + k) % NP;
            if (owner < 0 && req[c]) owner = c;
         end
`else
         for (int k = 0; k < NP; k++) begin
            if (owner < 0 && req[k]) owner = k;
         end
`endif
      end else if (!req[owner]) begin
         ptr   = owner;
         owner = -1;
      end
   endtask

   // Apply inputs away from the edge, clock once, advance the model, settle.
   task automatic drive_edge(input logic [NP-1:0] req, input logic rst);
      @(negedge clock);
      reset       = rst;
      bus.request = req;
      rand_data();
      @(posedge clock);
      model_edge(req, rst);
      #1;
   endtask

   task automatic test_reset();
      drive_edge(16'hffff, 1'b1);
      tests++;
      if (obs_vec() !== exp_vec()) begin
         failed++;
         $display("FAIL reset_vec: got %h want %h", obs_vec(), exp_vec());
      end
      tests++;
      if ({bus.grant, bus.busy, bus.grant_id} !== 21'h0) begin
         failed++;
         $display("FAIL reset_state: got grant=%h busy=%b id=%0d want all zero",
                  bus.grant, bus.busy, bus.grant_id);
      end
   endtask

   task automatic test_basic();
      logic [NP-1:0] want;
      drive_edge(16'h0000, 1'b1);
      drive_edge(16'hfff0, 1'b0);
      tests++;
      if (bus.grant !== 16'h0010 || bus.busy !== 1'b1 || bus.grant_id !== 4'd4) begin
         failed++;
         $display("FAIL first_grant: got grant=%h busy=%b id=%0d want 0010 1 4",
                  bus.grant, bus.busy, bus.grant_id);
      end
      for (int i = 0; i < 4; i++) begin
         drive_edge(16'hfff5, 1'b0);
         tests++;
         if (bus.grant !== 16'h0010 || obs_vec() !== exp_vec()) begin
            failed++;
            $display("FAIL hold: got %h want %h", obs_vec(), exp_vec());
         end
      end
      drive_edge(16'hff01, 1'b0);
      tests++;
      if ({bus.grant, bus.busy, bus.frame_n_o, bus.valid_n_o, bus.din_o} !== {17'h0, 3'b110}) begin
         failed++;
         $display("FAIL release_idle: got %h want idle", obs_vec());
      end
      drive_edge(16'hff01, 1'b0);
`ifdef RR_ARB_EN
      want = 16'h0100;
`else
      want = 16'h0001;
`endif
      tests++;
      if (bus.grant !== want || obs_vec() !== exp_vec()) begin
         failed++;
         $display("FAIL next_winner: got grant=%h want %h", bus.grant, want);
      end
      drive_edge(16'h0100, 1'b0);
      tests++;
      if (obs_vec() !== exp_vec()) begin
         failed++;
         $display("FAIL single_req: got %h want %h", obs_vec(), exp_vec());
      end
`ifdef RR_ARB_EN
      tests++;
      if (bus.grant !== 16'h0100) begin
         failed++;
         $display("FAIL single_hold: got grant=%h want 0100", bus.grant);
      end
`endif
      for (int i = 0; i < 2; i++) begin
         drive_edge(16'h0000, 1'b0);
         tests++;
         if (bus.grant !== 16'h0 || bus.busy !== 1'b0 || obs_vec() !== exp_vec()) begin
            failed++;
            $display("FAIL drop_idle: got %h want %h", obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_fairness();
      logic [NP-1:0] want;
      drive_edge(16'h0000, 1'b1);
      for (int r = 0; r <= NP; r++) begin
         drive_edge(16'hffff, 1'b0);
`ifdef RR_ARB_EN
         want = 16'(1) << (r % NP);
`else
         want = 16'h0001;
`endif
         tests++;
         if (bus.grant !== want || obs_vec() !== exp_vec()) begin
            failed++;
            $display("FAIL rotate_%0d: got grant=%h want %h", r, bus.grant, want);
         end
         drive_edge(16'hffff & ~want, 1'b0);
         tests++;
         if (bus.grant !== 16'h0 || bus.busy !== 1'b0) begin
            failed++;
            $display("FAIL rotate_gap_%0d: got grant=%h busy=%b want 0 0", r, bus.grant, bus.busy);
         end
      end
   endtask

   task automatic test_reset_mid_grant();
      drive_edge(16'h0000, 1'b1);
      drive_edge(16'h0100, 1'b0);
      tests++;
      if (bus.grant !== 16'h0100) begin
         failed++;
         $display("FAIL mid_setup: got grant=%h want 0100", bus.grant);
      end
      drive_edge(16'hffff, 1'b1);
      tests++;
      if ({bus.grant, bus.busy, bus.grant_id} !== 21'h0) begin
         failed++;
         $display("FAIL mid_reset: got grant=%h busy=%b id=%0d want 0 0 0",
                  bus.grant, bus.busy, bus.grant_id);
      end
      drive_edge(16'hffff, 1'b0);
      tests++;
      if (bus.grant !== 16'h0001 || obs_vec() !== exp_vec()) begin
         failed++;
         $display("FAIL ptr_reset: got grant=%h want 0001", bus.grant);
      end
   endtask

   // Data inputs change mid-cycle; outputs must follow with no clock.
   task automatic test_data_select();
      drive_edge(16'h0000, 1'b0);
      drive_edge(16'h2000, 1'b0);
      for (int i = 0; i < 8; i++) begin
         rand_data();
         #1;
         tests++;
         if (obs_vec() !== exp_vec()) begin
            failed++;
            $display("FAIL data_comb_%0d: got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      drive_edge(16'h0000, 1'b0);
      rand_data();
      #1;
      tests++;
      if ({bus.frame_n_o, bus.valid_n_o, bus.din_o} !== 3'b110) begin
         failed++;
         $display("FAIL data_idle: got %b want 110", {bus.frame_n_o, bus.valid_n_o, bus.din_o});
      end
   endtask

   task automatic test_random();
      logic [NP-1:0] req;
      logic          rst;
      for (int i = 0; i < 500; i++) begin
         case ($urandom_range(0, 3))
            0:       req = 16'($urandom);
            1:       req = 16'($urandom) & 16'($urandom) & 16'($urandom);
            2:       req = 16'(1) << $urandom_range(0, NP - 1);
            default: req = '0;
         endcase
         if (owner >= 0 && $urandom_range(0, 3) != 0) req[owner] = 1'b1;
         rst = ($urandom_range(0, 49) == 0);
         drive_edge(req, rst);
         tests++;
         if (obs_vec() !== exp_vec()) begin
            failed++;
            $display("FAIL random_%0d: req=%h rst=%b got %h want %h", i, req, rst,
                     obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      bus.request = '0;
      rand_data();
      repeat (2) @(posedge clock);
      test_reset();
      test_basic();
      test_fairness();
      test_reset_mid_grant();
      test_data_select();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/arbiter_router_top.md
Name: arbiter_router_top

Overview:
- 16-port input arbiter plus data-path select for the packet router.
- Each input port raises a request bit. The block grants exactly one port (one-hot) and holds the grant until that port drops its request.
- The granted port's serial frame_n/valid_n/din bits are steered onto a single output lane feeding the router core.
- Combines the arbiter (grant/busy) and the enable/data-select stage in one clocked block.

Parameters:
- NPORTS, 16, number of input ports; request/grant/frame/valid/din widths; legal values are powers of two from 2 to 16.
- IDW, 4, width of grant_id; must equal log2(NPORTS).

Ports:
- clock, input, 1, single system clock; all state updates on its rising edge.
- reset, input, 1, synchronous active-high reset, sampled on the rising edge of clock.
- request, input, NPORTS, per-port request; bit i high = port i wants the output.
- frame_n, input, NPORTS, per-port active-low frame bit.
- valid_n, input, NPORTS, per-port active-low valid bit.
- din, input, NPORTS, per-port serial data bit.
- grant, output, NPORTS, registered one-hot grant; all-zero when idle.
- busy, output, 1, high while any grant bit is set (equals OR of grant).
- grant_id, output, IDW, binary index of the granted port; 0 when idle.
- frame_n_o, output, 1, frame_n of the granted port; 1 when idle.
- valid_n_o, output, 1, valid_n of the granted port; 1 when idle.
- din_o, output, 1, din of the granted port; 0 when idle.

Behaviour:
- Reset (reset=1 at an edge):
  - grant=0, busy=0, grant_id=0.
  - Priority pointer = NPORTS-1, so port 0 has top priority first.
  - Reset overrides everything, including mid-grant: the next cycle is IDLE.
- Two states: IDLE (grant==0) and OWNED (grant!=0).
- IDLE:
  - At each edge, if request!=0, select a winner per the arbitration rule and register grant one-hot.
  - Latency is 1 clock from request sampled to grant/busy high.
  - If request==0, remain IDLE.
- OWNED:
  - At each edge, if request[granted index]==1, hold the grant unchanged, whatever the other request bits do.
  - If request[granted index]==0, clear grant to 0 (go to IDLE) and set pointer = granted index.
  - Exactly one IDLE cycle (grant=0, busy=0) always separates two grants; no direct grant-to-grant switching.
- Arbitration rule (RR_ARB_EN defined): round-robin.
  - Search request bits starting at pointer+1, incrementing modulo NPORTS.
  - First set bit wins.
- Single requester: wins regardless of pointer.
- Requests arriving while OWNED are not queued; they are re-evaluated in IDLE.
- grant is always one-hot or zero; never more than one bit set.
- Data select is combinational from the registered grant:
  - frame_n_o = frame_n[k], valid_n_o = valid_n[k], din_o = din[k], where k = granted index.
  - Idle values apply when grant==0.
  - Zero cycles of latency from the data inputs to the outputs.
- X/unknown on request is not sanitized; the bench drives known values after reset.

Optional Feature:
- Macro RR_ARB_EN.
- Defined: round-robin arbitration with rotating pointer, as above.
- Undefined: fixed priority; lowest-index set request bit always wins in IDLE; pointer logic removed. Hold/release and data select are unchanged.

Test Plan:
- Reset, then request=16'hfff0 -> one clock later grant=16'h0010, busy=1, grant_id=4; frame_n_o/valid_n_o/din_o track bit 4 of the random frame_n/valid_n/din each cycle.
- While owned, request=16'hfff5 -> grant stays 16'h0010 (hold; bits 0 and 2 ignored).
- request=16'hff01 (bit 4 dropped):
  - Next edge: grant=0, busy=0, frame_n_o=1, valid_n_o=1, din_o=0.
  - Following edge: grant=16'h0100 (search from 5, so port 8 wins over port 0 under RR_ARB_EN).
  - Fixed priority: grant=16'h0001.
- request=16'h0100 -> grant stays 16'h0100; then request=0 -> grant=0 next edge, busy=0 and stays idle.
- Fairness: hold request=16'hffff, dropping each owner's bit for one cycle after one cycle of ownership -> grants rotate 0x0001, 0x0002, …, 0x8000, 0x0001 (wrap-around), each separated by one idle cycle.
- Reset asserted while grant=16'h0100 -> next edge grant=0, busy=0, grant_id=0. After release with request=16'hffff -> grant=16'h0001 (pointer reset).
